// File: rtl/proc_pkg.sv
// proc_pkg: shared fetch widths, funct field slices, fetch state and queue entry types
package proc_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 10;
  localparam int FETCH_DEPTH = 2;
  localparam logic [ADDR_W-1:0] PC_INC = 8'd4;
  localparam int FUNCT_HI = 9;
  localparam int FUNCT_LO = 6;
  localparam int OPND_HI = 5;
  localparam int OPND_LO = 0;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
  function automatic logic [FUNCT_HI-FUNCT_LO:0] funct_of(input logic [INSTR_W-1:0] i);
    return i[FUNCT_HI:FUNCT_LO];
  endfunction
endpackage

// File: rtl/adder.sv
// adder: unsigned modular adder
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO with flush; push+pop in one cycle is legal even when full
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop && !flush));
endmodule

// File: rtl/flopr.sv
// flopr: resettable register, async active-high reset
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, in-order imem reads, prefetch queue, branch redirect; IFETCH_BYPASS_EN adds 0-cycle rdata->instr path
module instr_fetch
  import proc_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_adr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_t state;
  logic [CW-1:0] outstanding, drop, left, occ, tcount;
  logic [ADDR_W-1:0] pc, pc_inc, pc_next, tag_pc;
  fetch_entry_t head, wentry;
  logic rv, issue, keep, push, pop, empty, dfull, tfull, tempty;
  logic unused;
  assign unused = &{1'b0, dfull, tfull, tempty, tcount};
  // responses with nothing outstanding (e.g. left over from before reset) are ignored
  assign rv = imem_rvalid && outstanding != '0;
  assign imem_req = !reset && !branch_taken && ({1'b0, outstanding} + {1'b0, occ}) < (CW + 1)'(DEPTH);
  assign issue = imem_req && imem_gnt;
  assign keep = rv && state == RUN && !branch_taken;
  assign left = outstanding - CW'(rv);
  assign pop = !empty && instr_ready && !branch_taken;
  assign wentry = '{instr: imem_rdata, pc: tag_pc};
`ifdef IFETCH_BYPASS_EN
  logic byp;
  assign byp = empty && keep;
  assign instr_valid = !empty || byp;
  assign instr = byp ? imem_rdata : head.instr;
  assign instr_pc = byp ? tag_pc : head.pc;
  assign push = keep && !(byp && instr_ready);
`else
  assign instr_valid = !empty;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  assign push = keep;
`endif
  adder #(.WIDTH(ADDR_W)) u_inc (.a(pc), .b(PC_INC), .y(pc_inc));
  assign pc_next = branch_taken ? branch_target : issue ? pc_inc : pc;
  flopr #(.WIDTH(ADDR_W)) u_pc (.clk(clk), .reset(reset), .d(pc_next), .q(pc));
  assign imem_adr = pc;
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data (
    .clk(clk), .reset(reset), .flush(branch_taken), .push(push), .pop(pop),
    .wdata(wentry), .rdata(head), .full(dfull), .empty(empty), .count(occ)
  );
  // tag queue holds the PC of every live in-flight read, matched to responses in order
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .reset(reset), .flush(branch_taken), .push(issue), .pop(keep),
    .wdata(pc), .rdata(tag_pc), .full(tfull), .empty(tempty), .count(tcount)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= left + CW'(issue);
      if (branch_taken) begin
        drop <= left;
        state <= left != '0 ? DRAIN : RUN;
      end else if (rv && state == DRAIN) begin
        drop <= drop - CW'(1);
        state <= drop == CW'(1) ? RUN : DRAIN;
      end
    end
endmodule
